// File: rtl/gradient_magnitude_pipe.sv
// rtl/gradient_magnitude_pipe.sv - three-stage Sobel gradient/magnitude engine, LANES pixels per beat.
// Optional gdir direction output enabled by defining GRAD_DIRECTION_EN.
module gradient_magnitude_pipe #(
    parameter int LANES = 5,
    parameter int PIX_W = 8,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3*(LANES+2)*PIX_W-1:0] win_in,
    input  logic [1:0]                  grad_shift,
    input  logic                        mag_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*OUT_W-1:0]      gx_abs,
    output logic [LANES*OUT_W-1:0]      gy_abs,
    output logic [LANES-1:0]            gx_neg,
    output logic [LANES-1:0]            gy_neg,
    output logic [LANES*OUT_W-1:0]      gmag,
    output logic [LANES-1:0]            sat,
    input  logic                        sat_clr,
    output logic [CNT_W-1:0]            sat_cnt
`ifdef GRAD_DIRECTION_EN
    ,
    output logic [LANES*2-1:0]          gdir
`endif
);

    localparam int COLS  = LANES + 2;
    localparam int WIN_W = 3 * COLS * PIX_W;
    localparam int GW    = PIX_W + 3;
    localparam logic [GW-1:0] SAT_LIM = GW'({OUT_W{1'b1}});

    function automatic logic [GW-1:0] px(input logic [WIN_W-1:0] w, input int r, input int c);
        return GW'(w[(r*COLS+c)*PIX_W +: PIX_W]);
    endfunction

    // Raw gradients are two's complement bit patterns; unsigned subtraction wraps correctly.
    function automatic logic [GW-1:0] sobel_x(input logic [WIN_W-1:0] w, input int k);
        logic [GW-1:0] pos, neg;
        pos = px(w, 0, k+2) + (px(w, 1, k+2) << 1) + px(w, 2, k+2);
        neg = px(w, 0, k) + (px(w, 1, k) << 1) + px(w, 2, k);
        return pos - neg;
    endfunction

    function automatic logic [GW-1:0] sobel_y(input logic [WIN_W-1:0] w, input int k);
        logic [GW-1:0] pos, neg;
        pos = px(w, 2, k) + (px(w, 2, k+1) << 1) + px(w, 2, k+2);
        neg = px(w, 0, k) + (px(w, 0, k+1) << 1) + px(w, 0, k+2);
        return pos - neg;
    endfunction

    // Returns {clip, magnitude} after abs, shift and clamp.
    function automatic logic [OUT_W:0] shrink(input logic [GW-1:0] g, input logic [1:0] sh);
        logic [GW-1:0] m;
        m = g[GW-1] ? (~g + GW'(1)) : g;
        m = m >> sh;
        if (m > SAT_LIM) return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, m[OUT_W-1:0]};
    endfunction

    function automatic logic [OUT_W:0] combine(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b,
                                               input logic mode);
        logic [OUT_W:0] s, mx, mn;
        if (mode) begin
            mx = (a >= b) ? {1'b0, a} : {1'b0, b};
            mn = (a >= b) ? {1'b0, b} : {1'b0, a};
            s  = mx + (mn >> 1);
        end else begin
            s = {1'b0, a} + {1'b0, b};
        end
        if (s[OUT_W]) return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, s[OUT_W-1:0]};
    endfunction

`ifdef GRAD_DIRECTION_EN
    function automatic logic [1:0] quant_dir(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b,
                                             input logic xn, input logic yn);
        if ({b, 1'b0} < {1'b0, a}) return 2'd0;
        if ({a, 1'b0} < {1'b0, b}) return 2'd2;
        return (xn == yn) ? 2'd1 : 2'd3;
    endfunction
`endif

    logic                        v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
    logic [LANES-1:0][GW-1:0]    gx1_q, gx1_d, gy1_q, gy1_d;
    logic [1:0]                  shift1_q, shift1_d;
    logic                        mode1_q, mode1_d, mode2_q, mode2_d;
    logic [LANES-1:0][OUT_W-1:0] gxa2_q, gxa2_d, gya2_q, gya2_d;
    logic [LANES-1:0]            gxn2_q, gxn2_d, gyn2_q, gyn2_d, clip2_q, clip2_d;
    logic [LANES-1:0][OUT_W-1:0] gxa3_q, gxa3_d, gya3_q, gya3_d, gmag3_q, gmag3_d;
    logic [LANES-1:0]            gxn3_q, gxn3_d, gyn3_q, gyn3_d, sat3_q, sat3_d;
    logic [CNT_W-1:0]            sat_cnt_q, sat_cnt_d;
`ifdef GRAD_DIRECTION_EN
    logic [LANES-1:0][1:0]       gdir3_q, gdir3_d, dir_s2;
`endif

    logic                        advance;
    logic [LANES-1:0][GW-1:0]    gx_s0, gy_s0;
    logic [LANES-1:0][OUT_W:0]   gx_s1, gy_s1, mag_s2;

    assign advance = !out_valid_q || out_ready;

    always_comb begin
        gx_s0  = '0;
        gy_s0  = '0;
        gx_s1  = '0;
        gy_s1  = '0;
        mag_s2 = '0;
`ifdef GRAD_DIRECTION_EN
        dir_s2 = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            gx_s0[k]  = sobel_x(win_in, k);
            gy_s0[k]  = sobel_y(win_in, k);
            gx_s1[k]  = shrink(gx1_q[k], shift1_q);
            gy_s1[k]  = shrink(gy1_q[k], shift1_q);
            mag_s2[k] = combine(gxa2_q[k], gya2_q[k], mode2_q);
`ifdef GRAD_DIRECTION_EN
            dir_s2[k] = quant_dir(gxa2_q[k], gya2_q[k], gxn2_q[k], gyn2_q[k]);
`endif
        end
    end

    always_comb begin
        v1_d        = v1_q;
        gx1_d       = gx1_q;
        gy1_d       = gy1_q;
        shift1_d    = shift1_q;
        mode1_d     = mode1_q;
        v2_d        = v2_q;
        gxa2_d      = gxa2_q;
        gya2_d      = gya2_q;
        gxn2_d      = gxn2_q;
        gyn2_d      = gyn2_q;
        clip2_d     = clip2_q;
        mode2_d     = mode2_q;
        out_valid_d = out_valid_q;
        gxa3_d      = gxa3_q;
        gya3_d      = gya3_q;
        gxn3_d      = gxn3_q;
        gyn3_d      = gyn3_q;
        gmag3_d     = gmag3_q;
        sat3_d      = sat3_q;
`ifdef GRAD_DIRECTION_EN
        gdir3_d     = gdir3_q;
`endif
        if (advance) begin
            v1_d        = in_valid;
            gx1_d       = gx_s0;
            gy1_d       = gy_s0;
            shift1_d    = grad_shift;
            mode1_d     = mag_mode;
            v2_d        = v1_q;
            mode2_d     = mode1_q;
            out_valid_d = v2_q;
            for (int k = 0; k < LANES; k++) begin
                gxa2_d[k]  = gx_s1[k][OUT_W-1:0];
                gya2_d[k]  = gy_s1[k][OUT_W-1:0];
                gxn2_d[k]  = gx1_q[k][GW-1];
                gyn2_d[k]  = gy1_q[k][GW-1];
                clip2_d[k] = gx_s1[k][OUT_W] | gy_s1[k][OUT_W];
                gmag3_d[k] = mag_s2[k][OUT_W-1:0];
                sat3_d[k]  = mag_s2[k][OUT_W] | clip2_q[k];
            end
            gxa3_d = gxa2_q;
            gya3_d = gya2_q;
            gxn3_d = gxn2_q;
            gyn3_d = gyn2_q;
`ifdef GRAD_DIRECTION_EN
            gdir3_d = dir_s2;
`endif
        end
    end

    // Clear wins over a coincident saturated transfer; the count sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr)
            sat_cnt_d = '0;
        else if (out_valid_q && out_ready && (|sat3_q) && !(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            v1_q        <= 1'b0;
            gx1_q       <= '0;
            gy1_q       <= '0;
            shift1_q    <= '0;
            mode1_q     <= 1'b0;
            v2_q        <= 1'b0;
            gxa2_q      <= '0;
            gya2_q      <= '0;
            gxn2_q      <= '0;
            gyn2_q      <= '0;
            clip2_q     <= '0;
            mode2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            gxa3_q      <= '0;
            gya3_q      <= '0;
            gxn3_q      <= '0;
            gyn3_q      <= '0;
            gmag3_q     <= '0;
            sat3_q      <= '0;
            sat_cnt_q   <= '0;
`ifdef GRAD_DIRECTION_EN
            gdir3_q     <= '0;
`endif
        end else begin
            v1_q        <= v1_d;
            gx1_q       <= gx1_d;
            gy1_q       <= gy1_d;
            shift1_q    <= shift1_d;
            mode1_q     <= mode1_d;
            v2_q        <= v2_d;
            gxa2_q      <= gxa2_d;
            gya2_q      <= gya2_d;
            gxn2_q      <= gxn2_d;
            gyn2_q      <= gyn2_d;
            clip2_q     <= clip2_d;
            mode2_q     <= mode2_d;
            out_valid_q <= out_valid_d;
            gxa3_q      <= gxa3_d;
            gya3_q      <= gya3_d;
            gxn3_q      <= gxn3_d;
            gyn3_q      <= gyn3_d;
            gmag3_q     <= gmag3_d;
            sat3_q      <= sat3_d;
            sat_cnt_q   <= sat_cnt_d;
`ifdef GRAD_DIRECTION_EN
            gdir3_q     <= gdir3_d;
`endif
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign gx_abs    = gxa3_q;
    assign gy_abs    = gya3_q;
    assign gx_neg    = gxn3_q;
    assign gy_neg    = gyn3_q;
    assign gmag      = gmag3_q;
    assign sat       = sat3_q;
    assign sat_cnt   = sat_cnt_q;
`ifdef GRAD_DIRECTION_EN
    assign gdir      = gdir3_q;
`endif

endmodule

// File: tb/tb_gradient_magnitude_pipe.sv
// tb/tb_gradient_magnitude_pipe.sv - scoreboard bench for gradient_magnitude_pipe.
module tb_gradient_magnitude_pipe;

    localparam int LANES = 5;
    localparam int PIX_W = 8;
    localparam int OUT_W = 8;
    localparam int CNT_W = 16;
    localparam int COLS  = LANES + 2;
    localparam int WIN_W = 3 * COLS * PIX_W;

    logic                     clk = 1'b0;
    logic                     n_rst, in_valid, in_ready, mag_mode, out_valid, out_ready, sat_clr;
    logic [WIN_W-1:0]         win_in;
    logic [1:0]               grad_shift;
    logic [LANES*OUT_W-1:0]   gx_abs, gy_abs, gmag;
    logic [LANES-1:0]         gx_neg, gy_neg, sat;
    logic [CNT_W-1:0]         sat_cnt;
`ifdef GRAD_DIRECTION_EN
    logic [LANES*2-1:0]       gdir;
`endif

    gradient_magnitude_pipe #(.LANES(LANES), .PIX_W(PIX_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .win_in(win_in),
        .grad_shift(grad_shift), .mag_mode(mag_mode), .out_valid(out_valid), .out_ready(out_ready),
        .gx_abs(gx_abs), .gy_abs(gy_abs), .gx_neg(gx_neg), .gy_neg(gy_neg), .gmag(gmag),
        .sat(sat), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
`ifdef GRAD_DIRECTION_EN
        , .gdir(gdir)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*OUT_W-1:0] gxa, gya, gm;
        logic [LANES-1:0]       gxn, gyn, st;
        logic [LANES*2-1:0]     dir;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: Sobel kernels on an integer grid, then abs/shift/clamp and magnitude rules.
    function automatic exp_t model(input logic [WIN_W-1:0] w, input int sh, input int md);
        exp_t e;
        int p[3][COLS];
        int gx, gy, ax, ay, m, hi, lo, d;
        bit cl;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++)
                p[r][c] = int'(w[(r*COLS+c)*PIX_W +: PIX_W]);
        e.gxa = '0; e.gya = '0; e.gm = '0; e.gxn = '0; e.gyn = '0; e.st = '0; e.dir = '0;
        for (int k = 0; k < LANES; k++) begin
            gx = (p[0][k+2] + 2*p[1][k+2] + p[2][k+2]) - (p[0][k] + 2*p[1][k] + p[2][k]);
            gy = (p[2][k] + 2*p[2][k+1] + p[2][k+2]) - (p[0][k] + 2*p[0][k+1] + p[0][k+2]);
            ax = (gx < 0 ? -gx : gx) / (1 << sh);
            ay = (gy < 0 ? -gy : gy) / (1 << sh);
            cl = 0;
            if (ax > 255) begin ax = 255; cl = 1; end
            if (ay > 255) begin ay = 255; cl = 1; end
            hi = (ax > ay) ? ax : ay;
            lo = (ax > ay) ? ay : ax;
            m  = (md != 0) ? hi + lo / 2 : ax + ay;
            if (m > 255) begin m = 255; cl = 1; end
            if (2*ay < ax) d = 0;
            else if (2*ax < ay) d = 2;
            else d = ((gx < 0) == (gy < 0)) ? 1 : 3;
            e.gxa[k*OUT_W +: OUT_W] = ax[7:0];
            e.gya[k*OUT_W +: OUT_W] = ay[7:0];
            e.gm[k*OUT_W +: OUT_W]  = m[7:0];
            e.gxn[k] = (gx < 0);
            e.gyn[k] = (gy < 0);
            e.st[k]  = cl;
            e.dir[k*2 +: 2] = d[1:0];
        end
        return e;
    endfunction

    logic [CNT_W-1:0] exp_cnt = '0;
    bit               cnt_armed = 0, rst_check = 0, held = 0, xfer_sat;
    logic [159:0]     held_v;

    always @(negedge clk) begin
        exp_t e;
        if (cnt_armed) check("sat_cnt", 160'(sat_cnt), 160'(exp_cnt));
        if (rst_check) begin
            check("reset_out_valid", 160'(out_valid), 160'(0));
            check("reset_outputs", 160'({gx_abs, gy_abs, gx_neg, gy_neg, gmag, sat}), 160'(0));
            rst_check = 0;
        end
        if (n_rst) begin
            sb.delete();
            exp_cnt   = '0;
            cnt_armed = 1;
            rst_check = 1;
            held      = 0;
        end else begin
            if (held) check("stall_hold", 160'({out_valid, gx_abs, gy_abs, gx_neg, gy_neg, gmag, sat}), held_v);
            held = 0;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 160'(in_ready), 160'(0));
                held   = 1;
                held_v = 160'({out_valid, gx_abs, gy_abs, gx_neg, gy_neg, gmag, sat});
            end
            xfer_sat = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 160'(1), 160'(0));
                end else begin
                    e = sb.pop_front();
                    check("gx_abs", 160'(gx_abs), 160'(e.gxa));
                    check("gy_abs", 160'(gy_abs), 160'(e.gya));
                    check("gx_neg", 160'(gx_neg), 160'(e.gxn));
                    check("gy_neg", 160'(gy_neg), 160'(e.gyn));
                    check("gmag", 160'(gmag), 160'(e.gm));
                    check("sat", 160'(sat), 160'(e.st));
`ifdef GRAD_DIRECTION_EN
                    check("gdir", 160'(gdir), 160'(e.dir));
`endif
                    xfer_sat = (e.st != '0);
                end
            end
            if (sat_clr) exp_cnt = '0;
            else if (xfer_sat && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
            if (in_valid && in_ready) sb.push_back(model(win_in, int'(grad_shift), int'(mag_mode)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the beat on the inputs until the DUT takes it; returns just after that edge.
    task automatic send(input logic [WIN_W-1:0] w, input int sh, input int md);
        bit acc;
        in_valid   = 1'b1;
        win_in     = w;
        grad_shift = sh[1:0];
        mag_mode   = md[0];
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) return;
        end
        check("send_timeout", 160'(1), 160'(0));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        check("drain_empty", 160'(sb.size()), 160'(0));
    endtask

    function automatic logic [WIN_W-1:0] win_fn(input int kind, input int a, input int b);
        logic [WIN_W-1:0] w;
        int v;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++) begin
                case (kind)
                    0: v = a;
                    1: v = (c == 0) ? a : b;
                    2: v = a * (r + c);
                    default: v = $urandom_range(0, 255);
                endcase
                w[(r*COLS+c)*PIX_W +: PIX_W] = v[7:0];
            end
        return w;
    endfunction

    initial begin
        n_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        win_in = '0; grad_shift = '0; mag_mode = 1'b0;
        repeat (3) step();
        n_rst = 1'b0;
        step();

        send(win_fn(0, 100, 0), 0, 0);
        send(win_fn(1, 0, 255), 0, 0);
        send(win_fn(1, 0, 255), 2, 0);
        send(win_fn(1, 255, 0), 0, 0);
        send(win_fn(2, 25, 0), 1, 0);
        send(win_fn(2, 25, 0), 1, 1);
        send(win_fn(2, 25, 0), 1, 0);
        drain();

        fork
            begin
                for (int i = 0; i < 6; i++) send(win_fn(3, 0, 0), i % 4, i % 2);
                in_valid = 1'b0;
            end
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (5) step();
                out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send(win_fn(1, 0, 255), 0, 0);
        in_valid = 1'b0;
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        step();

        send(win_fn(1, 0, 255), 0, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("sat_clr_beat_seen", 160'(out_valid), 160'(1));
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        drain();

        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            win_in     = ($urandom_range(0, 3) == 0) ? win_fn(1, $urandom_range(0, 255), $urandom_range(0, 255))
                                                     : win_fn(3, 0, 0);
            grad_shift = 2'($urandom_range(0, 3));
            mag_mode   = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 9) < 7);
            sat_clr    = ($urandom_range(0, 19) == 0);
            step();
        end
        sat_clr = 1'b0;
        drain();
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
